// File: rtl/divider_if.sv
// Start/done handshake bundle between a division controller and the divider.
// The controller drives request and operands; the divider returns registered results.
interface divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Unsigned restoring divider: one quotient bit per clock, registered Q/R with a done pulse.
// A zero divisor skips iteration and reports all-ones quotient, remainder equal to A.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // After a restoring step the remainder is below the divisor, so its top bit is always
  // zero and only the trial value needs the extra bit.
  always_comb begin
    trial = {rem, dividend[WIDTH-1]};
    fits  = trial >= {1'b0, divisor};
    diff  = trial[WIDTH-1:0] - divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      dividend        <= '0;
      divisor         <= '0;
      rem             <= '0;
      quo             <= '0;
      cnt             <= '0;
      dz              <= 1'b0;
      bus.Q           <= '0;
      bus.R           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            dividend        <= bus.A;
            divisor         <= bus.B;
            rem             <= '0;
            quo             <= '0;
            cnt             <= '0;
            dz              <= (bus.B == '0);
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b1;
            state           <= (bus.B == '0) ? StFin : StRun;
          end
        end
        StRun: begin
          dividend <= dividend << 1;
          rem      <= fits ? diff : trial[WIDTH-1:0];
          quo      <= {quo[WIDTH-2:0], fits};
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= StFin;
        end
        StFin: begin
          // On a zero divisor the dividend register was never shifted and still holds A.
          bus.Q           <= dz ? '1 : quo;
          bus.R           <= dz ? dividend : rem;
          bus.div_by_zero <= dz;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed vector table plus corner sequences on an 8-bit divider, and a start-held
// random run on 8- and 32-bit instances checking the division invariant and done spacing.
module tb_divider;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divider_if #(.WIDTH(8))  d8 ();
  divider_if #(.WIDTH(32)) d32 ();

  divider #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst), .bus(d8.slave));
  divider #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst), .bus(d32.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
    string      nm;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Issue one 8-bit division and check latency, held outputs, result and done width.
  task automatic run8(input vec_t v);
    logic [7:0] pq;
    logic [7:0] pr;
    int         n;
    bit         got;
    pq = d8.Q;
    pr = d8.R;
    d8.A = v.a;
    d8.B = v.b;
    d8.start = 1'b1;
    @(posedge clk); #1;
    d8.start = 1'b0;
    check({v.nm, "_busy_start"}, 64'(d8.busy), 64'd1);
    check({v.nm, "_dz_cleared"}, 64'(d8.div_by_zero), 64'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (d8.done) got = 1'b1;
      else check({v.nm, "_q_held"}, 64'({d8.busy, d8.Q, d8.R}), 64'({1'b1, pq, pr}));
    end
    check({v.nm, "_latency"}, 64'(n), 64'(v.lat));
    check({v.nm, "_q"}, 64'(d8.Q), 64'(v.q));
    check({v.nm, "_r"}, 64'(d8.R), 64'(v.r));
    check({v.nm, "_dz"}, 64'(d8.div_by_zero), 64'(v.dz));
    check({v.nm, "_busy_done"}, 64'(d8.busy), 64'd0);
    @(posedge clk); #1;
    check({v.nm, "_done_pulse"}, 64'(d8.done), 64'd0);
  endtask

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (w == 8) begin
      d8.A = a[7:0];
      d8.B = b[7:0];
      d8.start = s;
    end else begin
      d32.A = a;
      d32.B = b;
      d32.start = s;
    end
  endtask

  // Start held high: a new operand pair is presented right after each done pulse.
  task automatic rand_run(input int w, input int n);
    logic [31:0]          mask;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          q;
    logic [31:0]          r;
    logic                 dn;
    longint unsigned      prod;
    int                   last;
    int                   waited;
    mask = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
    a = $urandom & mask;
    b = ($urandom >> $urandom_range(0, 31)) & mask;
    if (b == 0) b = 1;
    drive(w, a, b, 1'b1);
    last = 0;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      dn = 1'b0;
      while (!dn && waited < 200) begin
        @(posedge clk); #1;
        waited++;
        dn = (w == 8) ? d8.done : d32.done;
      end
      if (!dn) begin
        check("rand_timeout", 64'd0, 64'd1);
        break;
      end
      q = (w == 8) ? {24'd0, d8.Q} : d32.Q;
      r = (w == 8) ? {24'd0, d8.R} : d32.R;
      prod = longint'(q) * longint'(b) + longint'(r);
      check("rand_invariant", prod, 64'(a));
      check("rand_r_lt_b", 64'(r < b), 64'd1);
      if (i > 0) check("rand_spacing", 64'(cyc - last), 64'(w + 2));
      last = cyc;
      a = $urandom & mask;
      b = ($urandom >> $urandom_range(0, 31)) & mask;
      if (b == 0) b = 1;
      drive(w, a, b, i != n - 1);
    end
    drive(w, 32'd0, 32'd0, 1'b0);
    repeat (w + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   ndone;
    int   done_at;
    logic [7:0] cq;
    logic [7:0] cr;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9, "v100_7"};
    vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9, "v5_9"};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, "v255_1"};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9, "v255_255"};
    vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1, "v77_0"};
    vecs[5] = '{8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 9, "v10_3"};
    vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 9, "v0_5"};
    vecs[7] = '{8'd128, 8'd128, 8'd1,   8'd0,  1'b0, 9, "v128_128"};
    vecs[8] = '{8'd254, 8'd127, 8'd2,   8'd0,  1'b0, 9, "v254_127"};

    rst = 1'b1;
    drive(8, 32'd0, 32'd0, 1'b1);
    drive(32, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 64'(d8.Q), 64'd0);
    check("reset_r", 64'(d8.R), 64'd0);
    check("reset_flags", 64'({d8.busy, d8.done, d8.div_by_zero}), 64'd0);
    check("reset_busy32", 64'(d32.busy), 64'd0);
    rst = 1'b0;
    d8.start = 1'b0;

    for (int i = 0; i < 9; i++) run8(vecs[i]);

    // Start pulses at k+3 and k+8 land while busy and must be ignored.
    drive(8, 32'd200, 32'd13, 1'b1);
    @(posedge clk); #1;
    ndone = 0;
    done_at = 0;
    cq = 8'd0;
    cr = 8'd0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3 || c == 8) drive(8, 32'd1, 32'd1, 1'b1);
      else d8.start = 1'b0;
      @(posedge clk); #1;
      if (d8.done) begin
        ndone++;
        done_at = c;
        cq = d8.Q;
        cr = d8.R;
      end
    end
    check("ignore_done_count", 64'(ndone), 64'd1);
    check("ignore_done_edge", 64'(done_at), 64'd9);
    check("ignore_q", 64'(cq), 64'd15);
    check("ignore_r", 64'(cr), 64'd5);

    // Reset at k+4 abandons the division without a done pulse.
    drive(8, 32'd200, 32'd13, 1'b1);
    @(posedge clk); #1;
    d8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_q", 64'(d8.Q), 64'd0);
    check("midrst_r", 64'(d8.R), 64'd0);
    check("midrst_flags", 64'({d8.busy, d8.done, d8.div_by_zero}), 64'd0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (d8.done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run8('{8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9, "v9_2"});

    rand_run(8, 1000);
    rand_run(32, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential restoring divider that undoes what the shift-add multiplier builds: it takes an unsigned dividend and divisor and produces quotient and remainder one bit per clock. It sits beside the multiplier in the arithmetic datapath and uses a start/done handshake so a controller can issue one division at a time and collect a registered result.

## Interface
- WIDTH, 32, operand width in bits for A, B, Q and R; legal range 2..32.
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- start  input  1  request; sampled only while not busy.
- A  input  WIDTH  unsigned dividend; sampled at the accepted start edge.
- B  input  WIDTH  unsigned divisor; sampled at the accepted start edge.
- Q  output  WIDTH  quotient, registered, held until next accepted start.
- R  output  WIDTH  remainder, registered, held until next accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when Q/R become valid.
- div_by_zero  output  1  high with Q/R of a B==0 division; held until next accepted start.

## Operation
- States: IDLE, RUN, FIN.
- Reset (rst=1 at an edge): state IDLE; Q=0, R=0, busy=0, done=0, div_by_zero=0; counter, remainder, and quotient work registers cleared. rst has priority over start.
- IDLE, start=1: latch A into dividend shift register and B into divisor register; clear partial remainder (WIDTH+1 bits) and quotient register; counter=0; clear div_by_zero; busy=1. If B==0, go to FIN with the zero-divisor result; otherwise go to RUN.
- RUN, one iteration per edge:
  - trial = {partial_rem[WIDTH-1:0], dividend MSB};
  - shift dividend left by 1;
  - if trial >= {1'b0, divisor}: partial_rem = trial - divisor, shift 1 into quotient LSB;
  - else partial_rem = trial, shift 0 into quotient LSB;
  - counter += 1.
- When counter reaches WIDTH, go to FIN. Counter width is clog2(WIDTH+1).
- FIN, one cycle: Q <= quotient, R <= partial_rem[WIDTH-1:0], done=1, busy=0; next state IDLE.
- Divide by zero: Q = all ones, R = A, div_by_zero=1, with the same FIN/done pulse.
- start while busy (RUN or FIN) is ignored; operands are not re-sampled and Q/R are not disturbed.
- start in the same IDLE cycle that follows done is accepted normally; back-to-back divisions need no idle gap beyond the FIN cycle.
- Q, R, and div_by_zero change only at FIN or reset; intermediate iterations are never visible on the outputs.
- Arithmetic is unsigned only. The invariant A == Q*B + R with R < B holds for every B != 0.

## Timing
- Start accepted at edge k: busy=1 after edge k.
- B != 0: iterations at edges k+1 .. k+WIDTH; Q/R valid and done=1 after edge k+WIDTH+1; busy=0 after that same edge. Total latency is WIDTH+1 cycles.
- B == 0: Q/R/div_by_zero valid and done=1 after edge k+1. Latency is 1 cycle.
- done is high for exactly one cycle per accepted start and is never asserted without one.
- rst asserted mid-RUN or at FIN: after that edge everything returns to reset values, no done pulse is produced, and the division is abandoned.
- With start held high continuously, a new division is accepted on each IDLE edge, i.e. every WIDTH+2 cycles.

## Test plan
- WIDTH=8, A=100, B=7, 1-cycle start -> busy for 9 cycles; done pulse 9 edges after start; Q=14, R=2, div_by_zero=0.
- WIDTH=8, A=5, B=9 -> Q=0, R=5. Then A=255, B=1 -> Q=255, R=0. Then A=255, B=255 -> Q=1, R=0. Each result with latency 9.
- WIDTH=8, A=77, B=0 -> done 1 edge after start; Q=255, R=77, div_by_zero=1. Next division 10/3 -> div_by_zero clears at start; Q=3, R=1.
- Start 200/13; pulse start with A=1, B=1 at edges k+3 and k+8 -> both ignored; result Q=15, R=5; exactly one done pulse.
- Start 200/13; rst=1 at edge k+4 -> Q=0, R=0, busy=0, no done pulse. Then a new start 9/2 -> Q=4, R=1 at normal latency.
- Randomized 1000 pairs at WIDTH=8 and WIDTH=32, start held high -> every result satisfies A==Q*B+R and R<B; done spacing is WIDTH+2 cycles.
